// File: rtl/speech_pkg.sv
// Shared speech-path definitions: phrase geometry, terminator byte and the
// phrase reader state encoding (also used by the speech planner).
package speech_pkg;

  localparam int         PHRASE_LEN_DEF = 32;
  localparam logic [7:0] PHRASE_TERM    = 8'h00;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EMIT  = 2'd2,
    ST_DONE  = 2'd3
  } reader_state_t;

endpackage

// File: rtl/phrase_reader.sv
// Phrase reader: walks an aligned phrase in byte memory and streams the
// characters downstream until a terminator or the end of the phrase.
//
//   state    | meaning
//   ---------+-------------------------------------------------------
//   ST_IDLE  | waiting for start; base/offset hold the last phrase
//   ST_FETCH | mem_req high at base+offset, waiting for mem_ack
//   ST_EMIT  | char_valid high, waiting for char_ready
//   ST_DONE  | single-cycle done pulse, then back to idle
module phrase_reader
  import speech_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int PHRASE_LEN = PHRASE_LEN_DEF
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              start,
  input  logic [ADDR_W-1:0] address,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [7:0]        mem_data,
  output logic              char_valid,
  output logic [7:0]        char_data,
  input  logic              char_ready
);

  localparam int                OFF_W      = $clog2(PHRASE_LEN);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(PHRASE_LEN - 1);
  localparam logic [OFF_W-1:0]  LAST_OFF   = OFF_W'(PHRASE_LEN - 1);

  reader_state_t     state, state_nxt;
  logic [ADDR_W-1:0] base, base_nxt;
  logic [OFF_W-1:0]  offset, offset_nxt;
  logic              mem_req_nxt;
  logic              char_valid_nxt;
  logic [7:0]        char_data_nxt;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state      <= ST_IDLE;
      base       <= '0;
      offset     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      char_valid <= 1'b0;
      char_data  <= '0;
    end else begin
      state      <= state_nxt;
      base       <= base_nxt;
      offset     <= offset_nxt;
      busy       <= (state_nxt != ST_IDLE);
      done       <= (state_nxt == ST_DONE);
      mem_req    <= mem_req_nxt;
      // base is aligned, so OR-ing in the offset is the same as adding it
      mem_addr   <= base_nxt | ADDR_W'(offset_nxt);
      char_valid <= char_valid_nxt;
      char_data  <= char_data_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    base_nxt       = base;
    offset_nxt     = offset;
    mem_req_nxt    = mem_req;
    char_valid_nxt = char_valid;
    char_data_nxt  = char_data;

    if (abort && (state != ST_IDLE)) begin
      // abort wins over any ack or transfer seen in the same cycle
      state_nxt      = ST_IDLE;
      mem_req_nxt    = 1'b0;
      char_valid_nxt = 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start && !abort) begin
            base_nxt    = address & ALIGN_MASK;
            offset_nxt  = '0;
            mem_req_nxt = 1'b1;
            state_nxt   = ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (mem_ack) begin
            mem_req_nxt = 1'b0;
            if (mem_data == PHRASE_TERM) begin
              state_nxt = ST_DONE;
            end else begin
              char_data_nxt  = mem_data;
              char_valid_nxt = 1'b1;
              state_nxt      = ST_EMIT;
            end
          end
        end
        ST_EMIT: begin
          if (char_ready) begin
            char_valid_nxt = 1'b0;
            if (offset == LAST_OFF) begin
              state_nxt = ST_DONE;
            end else begin
              offset_nxt  = offset + 1'b1;
              mem_req_nxt = 1'b1;
              state_nxt   = ST_FETCH;
            end
          end
        end
        ST_DONE: begin
          state_nxt = ST_IDLE;
        end
        default: begin
          state_nxt      = ST_IDLE;
          mem_req_nxt    = 1'b0;
          char_valid_nxt = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/phrase_reader.md
PHRASE_READER -- requirements
Module: phrase_reader

Interface
REQ-001 SHALL have parameter ADDR_W, default 16: width of the phrase base address and the memory address.
REQ-002 SHALL have parameter PHRASE_LEN, default 32: maximum bytes per phrase; a power of two; equals the phrase alignment.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port nrst, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1: one-cycle request to read a phrase.
REQ-006 SHALL have port address, input, ADDR_W: phrase base address from the speech planner.
REQ-007 SHALL have port abort, input, 1: cancels the phrase in progress.
REQ-008 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-009 SHALL have port done, output, 1: one-cycle pulse when a phrase ends normally.
REQ-010 SHALL have port mem_req, output, 1: byte read request to the phrase memory.
REQ-011 SHALL have port mem_addr, output, ADDR_W: byte address of the current read.
REQ-012 SHALL have port mem_ack, input, 1: read completion; mem_data is valid in the same cycle.
REQ-013 SHALL have port mem_data, input, 8: byte returned by the memory.
REQ-014 SHALL have port char_valid, output, 1: character available downstream.
REQ-015 SHALL have port char_data, output, 8: character byte.
REQ-016 SHALL have port char_ready, input, 1: downstream accepts a character.

Function
REQ-017 SHALL implement the FSM states IDLE, FETCH, EMIT and DONE.
REQ-018 In IDLE, start SHALL latch address with bits [log2(PHRASE_LEN)-1:0] forced to 0, clear the offset, and move to FETCH; mem_req SHALL rise the next cycle.
REQ-019 start SHALL be ignored while busy=1.
REQ-020 In FETCH, mem_req SHALL be held high with mem_addr = base + offset, stable until mem_ack.
REQ-021 On a mem_ack cycle, mem_data SHALL be registered and mem_req SHALL be low from the next cycle.
REQ-022 If the acked byte is 0x00 (terminator), the FSM SHALL go to DONE and emit no character.
REQ-023 If the acked byte is nonzero, the FSM SHALL go to EMIT; char_valid SHALL be high from the next cycle.
REQ-024 char_data SHALL stay stable while char_valid=1 and char_ready=0.
REQ-025 A transfer SHALL occur on a cycle with char_valid=1 and char_ready=1; char_valid SHALL drop the following cycle.
REQ-026 After a transfer with offset < PHRASE_LEN-1, the offset SHALL increment and the FSM SHALL return to FETCH; mem_req SHALL be high the cycle after the transfer.
REQ-027 After a transfer with offset = PHRASE_LEN-1, the FSM SHALL go to DONE; the offset SHALL never wrap and no read outside the phrase SHALL be issued.
REQ-028 DONE SHALL last exactly one cycle with done=1, then return to IDLE; start is accepted from IDLE the cycle after.
REQ-029 abort=1 in any non-IDLE state SHALL force IDLE on the next edge, deassert mem_req and char_valid, and produce no done pulse.
REQ-030 abort SHALL take priority over mem_ack and char_ready in the same cycle; an ack or transfer in that cycle is discarded.
REQ-031 abort in IDLE SHALL have no effect; start and abort together in IDLE SHALL be treated as abort, and no phrase SHALL start.
REQ-032 The memory side SHALL tolerate mem_req withdrawn without ack (abort case).
REQ-033 All outputs SHALL be registered.

Reset
REQ-034 nrst low SHALL asynchronously force IDLE, offset 0, base 0, busy=0, done=0, mem_req=0, mem_addr=0, char_valid=0, char_data=0.
REQ-035 Reset asserted mid-phrase SHALL discard the phrase; after release, the block SHALL wait for a new start.

Structure
REQ-036 PHRASE_LEN default, the terminator constant 0x00 and the FSM state encoding SHALL live in the shared speech package, which the speech planner also uses.
REQ-037 The block SHALL be a single module with no sub-module.

Verification
REQ-038 Verification SHALL cover: start with address=0x0A60, memory "HI",0x00, char_ready=1 -> reads at 0x0A60/61/62, chars 'H','I', one done pulse, busy low after.
REQ-039 Verification SHALL cover: address=0x0A7F -> first mem_addr=0x0A60 (low 5 bits masked).
REQ-040 Verification SHALL cover: 32 nonzero bytes, no terminator -> exactly 32 chars, last read at base+0x1F, done; no read at base+0x20.
REQ-041 Verification SHALL cover: char_ready low 5 cycles -> char_valid/char_data held stable, no new mem_req until the transfer.
REQ-042 Verification SHALL cover: abort during a pending mem_req -> mem_req low next cycle, IDLE, no done; a later start works normally.
REQ-043 Verification SHALL cover: nrst pulsed during EMIT -> all outputs 0 immediately; start pulses while busy -> ignored (single phrase output).
